dual_port_bram: RTL

DUAL_PORT_BRAM -- requirements
Module: dual_port_bram

---
 rtl/dual_port_bram.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dual_port_bram.sv
// ---------------------------------------------------------------------------
// dual_port_bram
//   True dual-port block RAM with byte enables, selectable read-during-write
//   behaviour, an optional output register, and a post-reset zero-fill.
//
// Parameters
//   DATA_W          word width in bits (multiple of 8)
//   ADDR_W          address width, depth = 2**ADDR_W words
//   RDW_MODE        same-port read-during-write: 0 = write-first, 1 = read-first
//   OUT_REG         1 adds an output register stage (read latency 2 instead of 1)
//   CLEAR_ON_RESET  1 zero-fills the whole memory after reset
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_*/b_*  en, we, be, addr   access request (we with be=0 is a read)
//   a_*/b_*  wdata              write data
//   a_*/b_*  rdata, rvalid      read data, one-cycle valid per accepted access
//   busy                        high while the zero-fill runs (ports ignored)
//   collision                   pulse one cycle after a same-address write/write
// ---------------------------------------------------------------------------
module dual_port_bram #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                busy,
    output logic                collision
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_ptr_reg;
    logic                collision_reg;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]                 p_en, p_we, p_acc, p_wr, p_be_any;
    logic [1:0][NB-1:0]         p_be;
    logic [1:0][ADDR_W-1:0]     p_addr;
    logic [1:0][DATA_W-1:0]     p_wdata;
    logic [1:0][DATA_W-1:0]     p_ram_q;
    logic [DATA_W-1:0]          p_rdata [2];
    logic                       p_rvalid [2];

    logic [DATA_W-1:0] mem [DEPTH];

    assign p_en     = {b_en, a_en};
    assign p_we     = {b_we, a_we};
    assign p_be     = {b_be, a_be};
    assign p_addr   = {b_addr, a_addr};
    assign p_wdata  = {b_wdata, a_wdata};
    assign p_be_any = {|b_be, |a_be};

    // Accesses only count in READY and never while reset is held.
    assign p_acc = p_en & {2{(state_reg == ST_READY) && rst_n}};
    assign p_wr  = p_acc & p_we & p_be_any;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_ptr_reg   <= '0;
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= p_wr[0] && p_wr[1] && (p_addr[0] == p_addr[1]);
            if (state_reg == ST_CLEAR) begin
                clr_ptr_reg <= clr_ptr_reg + 1'b1;
                if (clr_ptr_reg == '1) begin
                    state_reg <= ST_READY;
                end
            end
        end
    end

    assign busy      = (state_reg == ST_CLEAR);
    assign collision = collision_reg;

    // ---------------- memory array ----------------
    // Reads capture the pre-write word. Port B is written first so that on a
    // shared byte port A's later assignment wins.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            p_ram_q[p] <= mem[p_addr[p]];
        end
        if (state_reg == ST_CLEAR) begin
            mem[clr_ptr_reg] <= '0;
        end
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < NB; i++) begin
                if (p_wr[p] && p_be[p][i]) begin
                    mem[p_addr[p]][i*8 +: 8] <= p_wdata[p][i*8 +: 8];
                end
            end
        end
    end

    // ---------------- per-port read pipeline ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              s1_valid_reg;
            logic              s1_wr_reg;
            logic [NB-1:0]     s1_be_reg;
            logic [DATA_W-1:0] s1_wdata_reg;
            logic [DATA_W-1:0] be_mask;
            logic [DATA_W-1:0] word;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_reg <= 1'b0;
                    s1_wr_reg    <= 1'b0;
                    s1_be_reg    <= '0;
                    s1_wdata_reg <= '0;
                end else begin
                    s1_valid_reg <= p_acc[gi];
                    s1_wr_reg    <= p_acc[gi] & p_we[gi];
                    s1_be_reg    <= p_be[gi];
                    s1_wdata_reg <= p_wdata[gi];
                end
            end

            always_comb begin
                be_mask = '0;
                for (int i = 0; i < NB; i++) begin
                    be_mask[i*8 +: 8] = {8{s1_be_reg[i]}};
                end
            end

            // Write-first returns this port's own merged word; read-first the old one.
            assign word = (RDW_MODE == 0 && s1_wr_reg)
                        ? ((p_ram_q[gi] & ~be_mask) | (s1_wdata_reg & be_mask))
                        : p_ram_q[gi];

            if (OUT_REG != 0) begin : g_oreg
                logic              out_valid_reg;
                logic [DATA_W-1:0] out_data_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                    end else begin
                        out_valid_reg <= s1_valid_reg;
                        if (s1_valid_reg) begin
                            out_data_reg <= word;
                        end
                    end
                end

                assign p_rdata[gi]  = out_data_reg;
                assign p_rvalid[gi] = out_valid_reg;
            end else begin : g_noreg
                // The RAM output register has no reset, so a resettable hold
                // register supplies rdata between valid cycles.
                logic [DATA_W-1:0] hold_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        hold_reg <= '0;
                    end else if (s1_valid_reg) begin
                        hold_reg <= word;
                    end
                end

                assign p_rdata[gi]  = s1_valid_reg ? word : hold_reg;
                assign p_rvalid[gi] = s1_valid_reg;
            end
        end
    endgenerate

    assign a_rdata  = p_rdata[0];
    assign a_rvalid = p_rvalid[0];
    assign b_rdata  = p_rdata[1];
    assign b_rvalid = p_rvalid[1];

endmodule
